fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_pc_reg.sv | 22 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The enum includes an idle state used only between reset and the first fetch.
package fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;
    localparam logic [ADDR_W-1:0] PC_INCR = 64'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary before entering the PC.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program-counter register: asynchronous active-low reset to RESET_VAL,
// updated only when load_i is high.
module pc_reg #(
    parameter int             W         = 64,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RESET_VAL;
        end else if (load_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit with a one-entry
// holding register and redirect handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PC_RESET = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target
);

    fetch_state_t        state_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [ADDR_W-1:0]   instr_pc_q;
    logic [ADDR_W-1:0]   drain_addr_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic                pc_load;

    pc_reg #(
        .W         (ADDR_W),
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    // A redirect always wins over sequential advance; the latest one seen is kept.
    always_comb begin
        pc_load = 1'b0;
        pc_d    = pc_q;
        if (branch_taken) begin
            pc_load = 1'b1;
            pc_d    = align_word(branch_target);
        end else if (state_q == HOLD && instr_ready) begin
            pc_load = 1'b1;
            pc_d    = pc_q + PC_INCR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            drain_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (branch_taken) begin
                        // Without a same-cycle response the old request is still in flight.
                        if (!imem_valid) begin
                            state_q      <= DRAIN;
                            drain_addr_q <= pc_q;
                        end
                    end else if (imem_valid) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (branch_taken || instr_ready) begin
                        state_q <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit; inputs change and outputs are
// sampled on the falling clock edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic        branch_taken;
    logic [63:0] branch_target;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_RESET (64'h1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic rdy,
                         input logic br, input logic [63:0] tgt);
        imem_valid    = v;
        imem_rdata    = d;
        instr_ready   = rdy;
        branch_taken  = br;
        branch_target = tgt;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);

        // Reset state
        @(negedge clk);
        chk("rst_req",    {63'h0, imem_req},    64'h0);
        chk("rst_ivalid", {63'h0, instr_valid}, 64'h0);
        chk("rst_instr",  {32'h0, instr},       64'h0);
        chk("rst_ipc",    instr_pc,             64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("first_req",  {63'h0, imem_req}, 64'h1);
        chk("first_addr", imem_addr,         64'h1000);

        // Redirect to 0x0 before the response: drain old request first
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h0);
        @(negedge clk);
        chk("drain0_addr",   imem_addr,            64'h1000);
        chk("drain0_ivalid", {63'h0, instr_valid}, 64'h0);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("post_drain_addr", imem_addr,         64'h0);
        chk("post_drain_req",  {63'h0, imem_req}, 64'h1);

        // Zero-wait memory, decode always ready
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hF840_0000 | (32'(i) << 2), 1'b1, 1'b0, 64'h0);
            @(negedge clk);
            chk("zw_ivalid", {63'h0, instr_valid}, 64'h1);
            chk("zw_instr",  {32'h0, instr},       {32'h0, 32'hF840_0000 | (32'(i) << 2)});
            chk("zw_ipc",    instr_pc,             64'(i * 4));
            chk("zw_req_lo", {63'h0, imem_req},    64'h0);
            if (i < 2) begin
                drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
                @(negedge clk);
                chk("zw_fetch_ivalid", {63'h0, instr_valid}, 64'h0);
                chk("zw_fetch_addr",   imem_addr,            64'((i + 1) * 4));
            end
        end

        // Decode stalls five cycles; stray responses in HOLD are ignored
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 64'h0);
            chk("stall_instr", {32'h0, instr},       64'hF840_0008);
            chk("stall_ipc",   instr_pc,             64'h8);
            chk("stall_req",   {63'h0, imem_req},    64'h0);
            chk("stall_ivld",  {63'h0, instr_valid}, 64'h1);
        end
        @(negedge clk);
        chk("stall_end_instr", {32'h0, instr}, 64'hF840_0008);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);

        // Response arrives in the fourth request cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("slow_req",    {63'h0, imem_req},    64'h1);
            chk("slow_addr",   imem_addr,            64'hC);
            chk("slow_ivalid", {63'h0, instr_valid}, 64'h0);
            if (i == 3) drive(1'b1, 32'hAABB_CCDD, 1'b0, 1'b0, 64'h0);
            else        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        end
        @(negedge clk);
        chk("slow_ivalid_hi", {63'h0, instr_valid}, 64'h1);
        chk("slow_instr",     {32'h0, instr},       64'hAABB_CCDD);
        chk("slow_ipc",       instr_pc,             64'hC);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);

        // Misaligned redirect while request outstanding
        @(negedge clk);
        chk("br_pre_addr", imem_addr, 64'h10);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h103);
        @(negedge clk);
        chk("br_drain_addr",   imem_addr,            64'h10);
        chk("br_drain_ivalid", {63'h0, instr_valid}, 64'h0);
        drive(1'b1, 32'hBADB_AD00, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("br_new_addr",    imem_addr,            64'h100);
        chk("br_stale_instr", {32'h0, instr},       64'hAABB_CCDD);
        chk("br_new_ivalid",  {63'h0, instr_valid}, 64'h0);

        // Redirect coincident with response: response discarded
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b1, 64'h20);
        @(negedge clk);
        chk("same_cyc_addr",   imem_addr,            64'h20);
        chk("same_cyc_ivalid", {63'h0, instr_valid}, 64'h0);
        chk("same_cyc_instr",  {32'h0, instr},       64'hAABB_CCDD);
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("hold20_ipc", instr_pc, 64'h20);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 64'h40);
        @(negedge clk);
        chk("hold_br_addr", imem_addr,         64'h40);
        chk("hold_br_req",  {63'h0, imem_req}, 64'h1);

        // Two redirects while draining: latest target wins
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h200);
        @(negedge clk);
        chk("dd_addr1", imem_addr, 64'h40);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h300);
        @(negedge clk);
        chk("dd_addr2", imem_addr,         64'h40);
        chk("dd_req2",  {63'h0, imem_req}, 64'h1);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("dd_final_addr", imem_addr, 64'h300);

        // PC wrap at top of address space
        drive(1'b1, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("wrap_ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        chk("wrap_next_addr", imem_addr, 64'h0);

        // Reset asserted while draining, stale response during reset
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h500);
        @(negedge clk);
        chk("rd_drain_addr", imem_addr, 64'h0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("rd_ivalid_now", {63'h0, instr_valid}, 64'h0);
        chk("rd_req_now",    {63'h0, imem_req},    64'h0);
        chk("rd_instr_now",  {32'h0, instr},       64'h0);
        @(negedge clk);
        drive(1'b1, 32'hCAFE_CAFE, 1'b0, 1'b0, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rd_first_req",  {63'h0, imem_req},    64'h1);
        chk("rd_first_addr", imem_addr,            64'h1000);
        chk("rd_ivalid",     {63'h0, instr_valid}, 64'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("rd_stale_ign_ivalid", {63'h0, instr_valid}, 64'h0);
        chk("rd_stale_ign_addr",   imem_addr,            64'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
